// File: rtl/parity_pkg.sv
// Shared constants and helpers for the parity stream unit.
package parity_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // XOR reduction of a single byte; building block of the parity tree.
    function automatic logic byte_xor(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/parity_pipe_stage.sv
// Generic valid/ready register slice. Ready is combinational from downstream,
// so a full slice still accepts a word in the cycle its current word leaves.
module parity_pipe_stage #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Advance when empty or when the held word is taken downstream.
    always_comb begin
        ready_o = !valid_q || ready_i;
        valid_d = valid_q;
        data_d  = data_q;
        if (ready_o) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // Slice state; reset clears the payload too so outputs read 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/parity_stream_unit.sv
// Two-stage pipelined parity generator/checker with saturating error tally.
module parity_stream_unit
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    input  logic              In_Parity,
    input  logic              Mode_Odd,
    input  logic              Check_En,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Parity,
    output logic              Out_Err,
    output logic [CNT_W-1:0]  Err_Count,
    output logic              Err_Sticky,
    input  logic              Clr_Err
);

    localparam int unsigned NB  = DATA_W / 8;
    localparam int unsigned S1W = DATA_W + 3 + NB;
    localparam int unsigned S2W = DATA_W + 2;

    logic [NB-1:0]     in_part;
    logic [S1W-1:0]    s1_in, s1_out;
    logic [S2W-1:0]    s2_in, s2_out;
    logic              s1_valid, s1_ready;
    logic [DATA_W-1:0] s1_data;
    logic              s1_mode, s1_chk, s1_inpar;
    logic [NB-1:0]     s1_part;
    logic              s2_par, s2_err;
    logic              emit_err;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sticky_q, sticky_d;

    // Per-byte XOR partials, registered in S1.
    always_comb begin
        in_part = '0;
        for (int b = 0; b < NB; b++) begin
            in_part[b] = byte_xor(In_Data[8*b +: 8]);
        end
    end

    assign s1_in = {In_Data, Mode_Odd, Check_En, In_Parity, in_part};

    parity_pipe_stage #(.W(S1W)) u_s1 (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .valid_i (In_Valid),
        .ready_o (In_Ready),
        .data_i  (s1_in),
        .valid_o (s1_valid),
        .ready_i (s1_ready),
        .data_o  (s1_out)
    );

    assign s1_data  = s1_out[S1W-1 -: DATA_W];
    assign s1_mode  = s1_out[NB+2];
    assign s1_chk   = s1_out[NB+1];
    assign s1_inpar = s1_out[NB];
    assign s1_part  = s1_out[NB-1:0];

    // Final reduction, mode and check feeding S2.
    always_comb begin
        s2_par = (^s1_part) ^ (s1_mode == PAR_ODD);
        s2_err = s1_chk & (s1_inpar != s2_par);
        s2_in  = {s1_data, s2_par, s2_err};
    end

    parity_pipe_stage #(.W(S2W)) u_s2 (
        .clk_i   (Clk),
        .rst_i   (Rst),
        .valid_i (s1_valid),
        .ready_o (s1_ready),
        .data_i  (s2_in),
        .valid_o (Out_Valid),
        .ready_i (Out_Ready),
        .data_o  (s2_out)
    );

    assign Out_Data   = s2_out[S2W-1:2];
    assign Out_Parity = s2_out[1];
    assign Out_Err    = s2_out[0];

    assign emit_err = Out_Valid & Out_Ready & Out_Err;

    // Clear takes effect before a same-cycle error is counted.
    always_comb begin
        cnt_d    = Clr_Err ? '0 : cnt_q;
        sticky_d = (Clr_Err ? 1'b0 : sticky_q) | emit_err;
        if (emit_err && (cnt_d != {CNT_W{1'b1}})) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // Error tally state.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign Err_Count  = cnt_q;
    assign Err_Sticky = sticky_q;

endmodule

// File: tb/tb_parity_stream_unit.sv
// Directed self-checking bench for parity_stream_unit (8-bit and 2-bit counters).
module tb_parity_stream_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        In_Valid = 1'b0;
    logic [31:0] In_Data = '0;
    logic        In_Parity = 1'b0;
    logic        Mode_Odd = 1'b0;
    logic        Check_En = 1'b0;
    logic        Out_Ready = 1'b1;
    logic        Clr_Err = 1'b0;

    logic        In_Ready, Out_Valid, Out_Parity, Out_Err, Err_Sticky;
    logic [31:0] Out_Data;
    logic [7:0]  Err_Count;

    logic        c2_in_ready, c2_out_valid, c2_out_parity, c2_out_err, c2_sticky;
    logic [31:0] c2_out_data;
    logic [1:0]  c2_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int emits = 0;
    int first_emit = 0;
    int last_emit = 0;
    int exp_errs = 0;
    bit mon_en = 1'b0;
    logic [33:0] exp_q[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    parity_stream_unit #(.DATA_W(32), .CNT_W(8)) dut (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(In_Ready),
        .In_Data(In_Data), .In_Parity(In_Parity), .Mode_Odd(Mode_Odd),
        .Check_En(Check_En), .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
        .Out_Data(Out_Data), .Out_Parity(Out_Parity), .Out_Err(Out_Err),
        .Err_Count(Err_Count), .Err_Sticky(Err_Sticky), .Clr_Err(Clr_Err)
    );

    parity_stream_unit #(.DATA_W(32), .CNT_W(2)) dut_c2 (
        .Clk(Clk), .Rst(Rst), .In_Valid(In_Valid), .In_Ready(c2_in_ready),
        .In_Data(In_Data), .In_Parity(In_Parity), .Mode_Odd(Mode_Odd),
        .Check_En(Check_En), .Out_Valid(c2_out_valid), .Out_Ready(Out_Ready),
        .Out_Data(c2_out_data), .Out_Parity(c2_out_parity), .Out_Err(c2_out_err),
        .Err_Count(c2_count), .Err_Sticky(c2_sticky), .Clr_Err(Clr_Err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wdata(input int i);
        return 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0013);
    endfunction

    // Expected {data, parity, err} for stream word i.
    function automatic logic [33:0] wexp(input int i);
        logic [31:0] d;
        logic        p, e;
        d = wdata(i);
        p = (^d) ^ i[0];
        e = i[1] & (i[2] != p);
        return {d, p, e};
    endfunction

    task automatic drive_word(input int i);
        In_Data   = wdata(i);
        Mode_Odd  = i[0];
        Check_En  = i[1];
        In_Parity = i[2];
    endtask

    task automatic push(input logic [31:0] d, input logic odd, input logic chk,
                        input logic par);
        In_Data   = d;
        Mode_Odd  = odd;
        Check_En  = chk;
        In_Parity = par;
        In_Valid  = 1'b1;
        @(posedge Clk); #1;
        In_Valid  = 1'b0;
    endtask

    // Stream monitor: a word seen valid&ready here is taken at the next edge.
    always @(negedge Clk) begin
        if (mon_en && Out_Valid && Out_Ready) begin
            if (exp_q.size() == 0) begin
                check("extra_emit", 64'd1, 64'd0);
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                check("stream_data", 64'(Out_Data), 64'(e[33:2]));
                check("stream_parity", 64'(Out_Parity), 64'(e[1]));
                check("stream_err", 64'(Out_Err), 64'(e[0]));
                if (e[0]) exp_errs++;
            end
            emits++;
            if (emits == 1) first_emit = cyc;
            last_emit = cyc;
        end
    end

    initial begin
        int k;
        // 1: reset and idle
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;
        @(negedge Clk);
        check("rst_out_valid", 64'(Out_Valid), 64'd0);
        check("rst_out_data", 64'(Out_Data), 64'd0);
        check("rst_out_parity", 64'(Out_Parity), 64'd0);
        check("rst_out_err", 64'(Out_Err), 64'd0);
        check("rst_err_count", 64'(Err_Count), 64'd0);
        check("rst_sticky", 64'(Err_Sticky), 64'd0);
        check("rst_in_ready", 64'(In_Ready), 64'd1);
        @(posedge Clk); #1;

        // 2: even, generate only, 0x7 -> parity 1 after two cycles
        push(32'h0000_0007, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check("lat_not_yet", 64'(Out_Valid), 64'd0);
        @(negedge Clk);
        check("gen_valid", 64'(Out_Valid), 64'd1);
        check("gen_data", 64'(Out_Data), 64'h7);
        check("gen_parity", 64'(Out_Parity), 64'd1);
        check("gen_err", 64'(Out_Err), 64'd0);
        @(posedge Clk); #1;

        // 3: odd, check, all ones with parity 0 -> mismatch
        push(32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0);
        @(posedge Clk); #1;
        check("chk_parity", 64'(Out_Parity), 64'd1);
        check("chk_err", 64'(Out_Err), 64'd1);
        @(posedge Clk); #1;
        check("chk_count", 64'(Err_Count), 64'd1);
        check("chk_sticky", 64'(Err_Sticky), 64'd1);

        // 4: 16 back-to-back words, then a 5-cycle stall
        mon_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            drive_word(i);
            In_Valid = 1'b1;
            exp_q.push_back(wexp(i));
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("stream_count", 64'(emits), 64'd16);
        check("stream_span", 64'(last_emit - first_emit), 64'd15);

        Out_Ready = 1'b0;
        k = 16;
        for (int c = 0; c < 5; c++) begin
            drive_word(k);
            In_Valid = 1'b1;
            @(negedge Clk);
            check("stall_in_ready", 64'(In_Ready), (c < 2) ? 64'd1 : 64'd0);
            if (In_Ready) begin
                exp_q.push_back(wexp(k));
                k++;
            end
            if (c >= 2) begin
                check("stall_valid", 64'(Out_Valid), 64'd1);
                check("stall_data", 64'(Out_Data), 64'(wdata(16)));
            end
            @(posedge Clk); #1;
        end
        In_Valid  = 1'b0;
        Out_Ready = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        check("stall_total", 64'(emits), 64'd18);
        check("stall_leftover", 64'(exp_q.size()), 64'd0);
        check("stream_err_count", 64'(Err_Count), 64'(1 + exp_errs));
        mon_en = 1'b0;

        // 5: saturation with a 2-bit counter, clear coinciding with an error
        Clr_Err = 1'b1;
        @(posedge Clk); #1;
        Clr_Err = 1'b0;
        check("clr_count", 64'(Err_Count), 64'd0);
        check("clr_sticky", 64'(Err_Sticky), 64'd0);
        check("clr_c2_count", 64'(c2_count), 64'd0);
        In_Data   = 32'h0000_0001;
        Mode_Odd  = 1'b0;
        Check_En  = 1'b1;
        In_Parity = 1'b0;
        In_Valid  = 1'b1;
        repeat (5) @(posedge Clk);
        #1 In_Valid = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
        check("sat_c2_count", 64'(c2_count), 64'd3);
        check("sat_c2_sticky", 64'(c2_sticky), 64'd1);
        check("sat_count8", 64'(Err_Count), 64'd5);
        push(32'h0000_0001, 1'b0, 1'b1, 1'b0);
        @(posedge Clk); #1;
        check("clr6_valid", 64'(Out_Valid), 64'd1);
        Clr_Err = 1'b1;
        @(posedge Clk); #1;
        Clr_Err = 1'b0;
        check("clr6_c2_count", 64'(c2_count), 64'd1);
        check("clr6_count8", 64'(Err_Count), 64'd1);
        check("clr6_sticky", 64'(Err_Sticky), 64'd1);

        // 6: reset with both stages full
        Out_Ready = 1'b0;
        push(32'h1234_5678, 1'b0, 1'b0, 1'b0);
        push(32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0);
        check("full_valid", 64'(Out_Valid), 64'd1);
        check("full_in_ready", 64'(In_Ready), 64'd0);
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(negedge Clk);
        check("mid_rst_valid", 64'(Out_Valid), 64'd0);
        check("mid_rst_data", 64'(Out_Data), 64'd0);
        check("mid_rst_in_ready", 64'(In_Ready), 64'd1);
        check("mid_rst_count", 64'(Err_Count), 64'd0);
        Out_Ready = 1'b1;
        @(posedge Clk); #1;
        push(32'h0000_0003, 1'b1, 1'b0, 1'b0);
        @(negedge Clk);
        check("post_rst_not_yet", 64'(Out_Valid), 64'd0);
        @(negedge Clk);
        check("post_rst_valid", 64'(Out_Valid), 64'd1);
        check("post_rst_data", 64'(Out_Data), 64'h3);
        check("post_rst_parity", 64'(Out_Parity), 64'd1);
        @(posedge Clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
